// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a show-ahead FIFO. It pops one word per frame
// and shifts it out as start, DATA_WIDTH data bits (LSB first), then stop.
module fifo_uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int SB_TICK    = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  s_tick,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic                  rd,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  tx_done_tick
);

   localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
   localparam logic [TW-1:0] TICK_ONE = TW'(1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                r_state;
   logic [TW-1:0]         r_tick;
   logic [BW-1:0]         r_bit;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_tx;
   logic                  r_done;

   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_shift_nxt;

   // Gating with reset_n keeps the FIFO from being popped while held in reset.
   assign w_pop        = reset_n && (r_state == IDLE) && !empty;
   assign w_shift_nxt  = r_shift >> 1;
   assign rd           = w_pop;
   assign tx           = r_tx;
   assign tx_busy      = (r_state != IDLE);
   assign tx_done_tick = r_done;

   // Frame sequencer: state, baud tick/bit counters, shift register and registered line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift <= r_data;
                  r_tick  <= '0;
                  r_tx    <= 1'b0;
                  r_state <= START;
               end
            end
            START: begin
               if (s_tick) begin
                  if (r_tick == OS_LAST) begin
                     r_tick  <= '0;
                     r_bit   <= '0;
                     r_tx    <= r_shift[0];
                     r_state <= DATA;
                  end else begin
                     r_tick <= r_tick + TICK_ONE;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (r_tick == OS_LAST) begin
                     r_tick  <= '0;
                     r_shift <= w_shift_nxt;
                     if (r_bit == BIT_LAST) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                     end else begin
                        r_bit <= r_bit + BIT_ONE;
                        r_tx  <= w_shift_nxt[0];
                     end
                  end else begin
                     r_tick <= r_tick + TICK_ONE;
                  end
               end
            end
            STOP: begin
               r_tx <= 1'b1;
               if (s_tick) begin
                  if (r_tick == SB_LAST) begin
                     r_tick  <= '0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_tick <= r_tick + TICK_ONE;
                  end
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO models feed two instances (1 and 2
// stop bits) and a tick-counting UART decoder checks every frame against push order.
module tb_fifo_uart_tx;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic s_tick = 1'b0;

   logic       empty0 = 1'b1, empty1 = 1'b1;
   logic [7:0] r_data0 = 8'h00, r_data1 = 8'h00;
   logic       rd0, tx0, busy0, done0;
   logic       rd1, tx1, busy1, done1;

   logic [7:0] q0[$], wq0[$], exp0[$];
   logic [7:0] q1[$], wq1[$], exp1[$];

   int n_cmp = 0, n_err = 0;
   int cyc = 0, tick_no = 0, tdiv = 0;

   int         in_frame[2]   = '{0, 0};
   int         start_tick[2] = '{0, 0};
   int         prev_rel[2]   = '{0, 0};
   int         frames[2]     = '{0, 0};
   int         done_cyc[2]   = '{-100, -100};
   int         g1[2]         = '{0, 0};
   int         rd_cnt[2]     = '{0, 0};
   int         done_cnt[2]   = '{0, 0};
   logic [7:0] acc[2];

   fifo_uart_tx #(.DATA_WIDTH(8), .OVERSAMPLE(16), .SB_TICK(16)) dut0 (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .empty(empty0), .r_data(r_data0),
      .rd(rd0), .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0));

   fifo_uart_tx #(.DATA_WIDTH(8), .OVERSAMPLE(16), .SB_TICK(32)) dut1 (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .empty(empty1), .r_data(r_data1),
      .rd(rd1), .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1));

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         tdiv   = (tdiv + 1) % 4;
         s_tick = (tdiv == 0);
      end
   end

   always @(posedge clk) begin
      if (s_tick) tick_no++;
   end

   // FIFO models: pop on rd, then accept pending writes; outputs update after the edge
   always @(posedge clk) begin
      if (rd0) begin
         n_cmp++;
         if (q0.size() == 0) begin
            n_err++;
            $display("FAIL underflow0: rd=1 with empty FIFO, required no pop");
         end else void'(q0.pop_front());
      end
      while (wq0.size() > 0) q0.push_back(wq0.pop_front());
      empty0  <= (q0.size() == 0);
      r_data0 <= (q0.size() > 0) ? q0[0] : 8'h00;
   end

   always @(posedge clk) begin
      if (rd1) begin
         n_cmp++;
         if (q1.size() == 0) begin
            n_err++;
            $display("FAIL underflow1: rd=1 with empty FIFO, required no pop");
         end else void'(q1.pop_front());
      end
      while (wq1.size() > 0) q1.push_back(wq1.pop_front());
      empty1  <= (q1.size() == 0);
      r_data1 <= (q1.size() > 0) ? q1[0] : 8'h00;
   end

   task automatic decode(input int d, input logic t, input logic b, input logic dn, input logic r);
      int         rel;
      int         sbt;
      logic [7:0] e;
      sbt = (d == 0) ? 16 : 32;
      if (dn) done_cnt[d]++;
      if (r) rd_cnt[d]++;
      if (!reset_n) begin
         in_frame[d] = 0;
         return;
      end
      if (in_frame[d] == 0) begin
         if (t == 1'b0) begin
            in_frame[d]   = 1;
            start_tick[d] = tick_no;
            prev_rel[d]   = 0;
            acc[d]        = 8'h00;
            if (cyc - done_cyc[d] == 1) g1[d]++;
         end
      end else begin
         rel = tick_no - start_tick[d];
         if (rel != prev_rel[d]) begin
            prev_rel[d] = rel;
            if (rel == 8) begin
               n_cmp++;
               if (t !== 1'b0 || b !== 1'b1) begin
                  n_err++;
                  $display("FAIL start_bit%0d: tx=%b busy=%b, required tx=0 busy=1", d, t, b);
               end
            end else if (rel >= 24 && rel <= 136 && (rel - 24) % 16 == 0) begin
               acc[d][(rel - 24) / 16] = t;
               n_cmp++;
               if (b !== 1'b1) begin
                  n_err++;
                  $display("FAIL busy_data%0d: tx_busy=%b, required 1", d, b);
               end
            end else if (rel == 144 + sbt / 2) begin
               n_cmp++;
               if (t !== 1'b1 || b !== 1'b1) begin
                  n_err++;
                  $display("FAIL stop_bit%0d: tx=%b busy=%b, required tx=1 busy=1", d, t, b);
               end
            end else if (rel == 144 + sbt) begin
               n_cmp++;
               if (dn !== 1'b1 || b !== 1'b0) begin
                  n_err++;
                  $display("FAIL done_tick%0d: done=%b busy=%b, required done=1 busy=0", d, dn, b);
               end
               n_cmp++;
               if ((d == 0 ? exp0.size() : exp1.size()) == 0) begin
                  n_err++;
                  $display("FAIL frame_data%0d: got %02h, required no frame", d, acc[d]);
               end else begin
                  e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                  if (acc[d] !== e) begin
                     n_err++;
                     $display("FAIL frame_data%0d: got %02h, required %02h", d, acc[d], e);
                  end
               end
               frames[d]++;
               done_cyc[d] = cyc;
               in_frame[d] = 0;
            end
         end
      end
   endtask

   // UART decoder, sampling mid-bit by counting baud ticks from the start edge
   always @(negedge clk) begin
      cyc++;
      decode(0, tx0, busy0, done0, rd0);
      decode(1, tx1, busy1, done1, rd1);
   end

   task automatic push(input int d, input logic [7:0] v);
      int guard = 0;
      while (((d == 0) ? q0.size() + wq0.size() : q1.size() + wq1.size()) >= 4 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) begin
         n_cmp++;
         n_err++;
         $display("FAIL push_timeout%0d: FIFO stayed full, required space", d);
      end
      if (d == 0) begin
         wq0.push_back(v);
         exp0.push_back(v);
      end else begin
         wq1.push_back(v);
         exp1.push_back(v);
      end
   endtask

   task automatic wait_frames(input int d, input int target, input string name);
      int t = 0;
      while (frames[d] < target && t < 20000) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (frames[d] < target) begin
         n_err++;
         $display("FAIL %s: frames=%0d, required %0d before timeout", name, frames[d], target);
      end
   endtask

   task automatic check_int(input string name, input int got, input int req);
      n_cmp++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #12;
      n_cmp++;
      if (tx0 !== 1'b1 || rd0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 ||
          tx1 !== 1'b1 || rd1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: tx=%b%b rd=%b%b busy=%b%b done=%b%b, required tx=1 rd=0 busy=0 done=0",
                  tx0, tx1, rd0, rd1, busy0, busy1, done0, done1);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_idle;
      int bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || rd0 !== 1'b0 || busy0 !== 1'b0 || tx1 !== 1'b1 || rd1 !== 1'b0 || busy1 !== 1'b0)
            bad++;
      end
      check_int("idle_bad_cycles", bad, 0);
   endtask

   task automatic test_single;
      int r0 = rd_cnt[0], d0 = done_cnt[0], f0 = frames[0];
      push(0, 8'hA5);
      wait_frames(0, f0 + 1, "single_a5");
      repeat (20) @(negedge clk);
      check_int("single_rd_pulses", rd_cnt[0] - r0, 1);
      check_int("single_done_pulses", done_cnt[0] - d0, 1);
   endtask

   task automatic test_back_to_back;
      int r0 = rd_cnt[0], g0 = g1[0], f0 = frames[0];
      push(0, 8'h00);
      push(0, 8'hFF);
      push(0, 8'h3C);
      wait_frames(0, f0 + 3, "b2b_frames");
      repeat (20) @(negedge clk);
      check_int("b2b_rd_pulses", rd_cnt[0] - r0, 3);
      check_int("b2b_one_clk_gaps", g1[0] - g0, 2);
   endtask

   task automatic test_fill;
      int r0 = rd_cnt[0], d0 = done_cnt[0], g0 = g1[0], f0 = frames[0], t = 0;
      for (int i = 0; i < 4; i++) push(0, 8'($urandom));
      while (in_frame[0] == 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      push(0, 8'($urandom));
      wait_frames(0, f0 + 5, "fill_frames");
      repeat (200) @(negedge clk);
      check_int("fill_rd_pulses", rd_cnt[0] - r0, 5);
      check_int("fill_done_pulses", done_cnt[0] - d0, 5);
      check_int("fill_one_clk_gaps", g1[0] - g0, 4);
   endtask

   task automatic test_stop32;
      int r1 = rd_cnt[1], g0 = g1[1], f1 = frames[1];
      push(1, 8'($urandom));
      push(1, 8'($urandom));
      wait_frames(1, f1 + 2, "stop32_frames");
      repeat (20) @(negedge clk);
      check_int("stop32_rd_pulses", rd_cnt[1] - r1, 2);
      check_int("stop32_one_clk_gaps", g1[1] - g0, 1);
   endtask

   task automatic test_reset_mid;
      int t = 0, f0 = frames[0], r0;
      push(0, 8'h5A);
      push(0, 8'hC3);
      while (!(in_frame[0] != 0 && tick_no - start_tick[0] >= 68) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (tx0 !== 1'b1 || busy0 !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset_bit3: tx=%b busy=%b, required tx=1 busy=1", tx0, busy0);
      end
      void'(exp0.pop_front());
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || rd0 !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: tx=%b busy=%b rd=%b, required tx=1 busy=0 rd=0", tx0, busy0, rd0);
      end
      repeat (3) @(negedge clk);
      r0 = rd_cnt[0];
      reset_n = 1'b1;
      wait_frames(0, f0 + 1, "after_reset_frame");
      repeat (20) @(negedge clk);
      check_int("after_reset_rd_pulses", rd_cnt[0] - r0, 1);
   endtask

   task automatic test_random;
      int r0 = rd_cnt[0], d0 = done_cnt[0], f0 = frames[0];
      for (int i = 0; i < 6; i++) begin
         push(0, 8'($urandom));
         repeat ($urandom_range(0, 700)) @(negedge clk);
      end
      wait_frames(0, f0 + 6, "random_frames");
      repeat (20) @(negedge clk);
      check_int("random_rd_pulses", rd_cnt[0] - r0, 6);
      check_int("random_done_pulses", done_cnt[0] - d0, 6);
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_fill();
      test_stop32();
      test_reset_mid();
      test_random();
      check_int("leftover_expected0", exp0.size(), 0);
      check_int("leftover_expected1", exp1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
